// File: rtl/tilemap_ctrl.sv
// rtl/tilemap_ctrl.sv - tile map store shared by the display scan-out and a game request port
// Optional feature macro: TILEMAP_WRITE_BUFFER_EN (1-entry posted-write buffer)
module tilemap_ctrl #(
    parameter int ROWS       = 15,
    parameter int COLS       = 20,
    parameter int TILE_SHIFT = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       blank,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [1:0] tile_out,
    input  logic       req_valid,
    input  logic       req_we,
    input  logic [3:0] req_row,
    input  logic [4:0] req_col,
    input  logic [1:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [1:0] rsp_rdata,
    output logic       init_busy
);

    localparam int            DEPTH    = ROWS * COLS;
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [3:0]    ROWS_L   = 4'(ROWS);
    localparam logic [4:0]    COLS_L   = 5'(COLS);
    localparam logic [4:0]    COL_LAST = 5'(COLS - 1);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic          r_state;
    logic [AW-1:0] r_init_cnt;
    logic [3:0]    r_init_row;
    logic [4:0]    r_init_col;
    logic [1:0]    r_tile_out;
    logic          r_rsp_valid;
    logic [1:0]    r_rsp_rdata;

    // Single-port storage: exactly one address is presented per cycle.
    logic [1:0]    r_mem [0:DEPTH-1];
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic [1:0]    w_mem_wdata;
    logic [1:0]    w_mem_rdata;

    logic [3:0]    w_disp_row;
    logic [4:0]    w_disp_col;
    logic          w_disp_in_range;
    logic [AW-1:0] w_disp_idx;
    logic          w_game_in_range;
    logic [AW-1:0] w_game_idx;
    logic [1:0]    w_init_val;
    logic          w_run;
    logic          w_ready;
    logic          w_accept;
    logic          w_unused_low_bits;

    assign w_run      = (r_state == ST_RUN);
    assign w_init_val = r_init_row[1:0] + r_init_col[1:0];

    assign w_disp_row      = DrawY[TILE_SHIFT+3:TILE_SHIFT];
    assign w_disp_col      = DrawX[TILE_SHIFT+4:TILE_SHIFT];
    assign w_disp_in_range = (w_disp_row < ROWS_L) && (w_disp_col < COLS_L);
    assign w_disp_idx      = AW'(w_disp_row) * AW'(COLS) + AW'(w_disp_col);

    assign w_game_in_range = (req_row < ROWS_L) && (req_col < COLS_L);
    assign w_game_idx      = AW'(req_row) * AW'(COLS) + AW'(req_col);

    // Sub-tile pixel bits and the top scan bits do not select a tile.
    assign w_unused_low_bits = ^{DrawX, DrawY};

`ifdef TILEMAP_WRITE_BUFFER_EN
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_addr;
    logic [1:0]    r_wb_data;

    // While blanking is low the buffer drains first, so that cycle refuses new requests.
    assign w_ready = w_run && !r_wb_valid && (!blank || req_we);
`else
    assign w_ready = w_run && !blank;
`endif

    assign w_accept  = req_valid && w_ready;
    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign tile_out  = r_tile_out;
    assign init_busy = (r_state == ST_INIT);

    // Storage port owner: init sequencer, then display during active video, then buffer drain, then game port.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        if (!w_run) begin
            w_mem_addr  = r_init_cnt;
            w_mem_we    = 1'b1;
            w_mem_wdata = w_init_val;
        end else if (blank) begin
            w_mem_addr = w_disp_idx;
`ifdef TILEMAP_WRITE_BUFFER_EN
        end else if (r_wb_valid) begin
            w_mem_addr  = r_wb_addr;
            w_mem_we    = 1'b1;
            w_mem_wdata = r_wb_data;
`endif
        end else begin
            w_mem_addr  = w_game_idx;
            w_mem_we    = w_accept && req_we && w_game_in_range;
            w_mem_wdata = req_wdata;
        end
    end

    assign w_mem_rdata = r_mem[w_mem_addr];

    // Storage write; contents are rebuilt by the init sequence, so no reset here.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // INIT/RUN sequencing with a row-major walk of the whole map.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_init_row <= '0;
            r_init_col <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_init_cnt == LAST_IDX) begin
                r_state <= ST_RUN;
            end else begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_col == COL_LAST) begin
                    r_init_col <= '0;
                    r_init_row <= r_init_row + 1'b1;
                end else begin
                    r_init_col <= r_init_col + 1'b1;
                end
            end
        end
    end

    // Display tile register: one cycle behind the scan coordinate.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tile_out <= '0;
        end else if (w_run && blank && w_disp_in_range) begin
            r_tile_out <= w_mem_rdata;
        end else begin
            r_tile_out <= '0;
        end
    end

    // Read response: a single-cycle strobe after each accepted read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_accept && !req_we;
            if (w_accept && !req_we) begin
                r_rsp_rdata <= w_game_in_range ? w_mem_rdata : 2'b00;
            end
        end
    end

`ifdef TILEMAP_WRITE_BUFFER_EN
    // Posted-write buffer: filled by writes accepted during active video, drained on the next blanking cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_run && !blank && r_wb_valid) begin
            r_wb_valid <= 1'b0;
        end else if (w_accept && blank) begin
            r_wb_valid <= w_game_in_range;
            r_wb_addr  <= w_game_idx;
            r_wb_data  <= req_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_tilemap_ctrl.sv
// tb/tb_tilemap_ctrl.sv - randomized self-checking bench for tilemap_ctrl against an array model
module tb_tilemap_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       blank;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [1:0] tile_out;
    logic       req_valid;
    logic       req_we;
    logic [3:0] req_row;
    logic [4:0] req_col;
    logic [1:0] req_wdata;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_rdata;
    logic       init_busy;

    int total = 0;
    int bad   = 0;
    int model [15][20];

    tilemap_ctrl dut (
        .Clk(Clk), .Reset(Reset), .blank(blank), .DrawX(DrawX), .DrawY(DrawY),
        .tile_out(tile_out), .req_valid(req_valid), .req_we(req_we),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .init_busy(init_busy)
    );

    always #5 Clk = ~Clk;

    function automatic void model_init();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
                model[r][c] = (r + c) % 4;
    endfunction

    function automatic int model_read(input int r, input int c);
        if (r < 15 && c < 20) return model[r][c];
        return 0;
    endfunction

    function automatic void model_write(input int r, input int c, input int v);
        if (r < 15 && c < 20) model[r][c] = v;
    endfunction

    function automatic int model_tile(input int x, input int y, input logic bl);
        int r, c;
        r = (y / 32) % 16;
        c = (x / 32) % 32;
        if (!bl) return 0;
        return model_read(r, c);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one request, waits (bounded) for acceptance, and samples the cycle after.
    task automatic game_req(input logic we, input int r, input int c, input int wd,
                            output logic ok, output logic got, output logic [1:0] data);
        int n;
        req_we = we; req_row = 4'(r); req_col = 5'(c); req_wdata = 2'(wd); req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        ok = req_ready;
        got = 1'b0;
        data = 2'b00;
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        got  = rsp_valid;
        data = rsp_rdata;
    endtask

    // Counts cycles of init_busy after a reset release, bounded.
    task automatic count_init(output int n, output int ready_seen);
        n = 0;
        ready_seen = 0;
        while (init_busy && n < 1000) begin
            if (req_ready) ready_seen++;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; blank = 1'b0; DrawX = '0; DrawY = '0;
        req_valid = 1'b1; req_we = 1'b0; req_row = '0; req_col = '0; req_wdata = '0;
        repeat (3) tick();
        total++; if (tile_out !== 2'd0)  begin bad++; $display("FAIL reset_tile_out got=%0d exp=0", tile_out); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 2'd0) begin bad++; $display("FAIL reset_rsp_rdata got=%0d exp=0", rsp_rdata); end
        total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL reset_init_busy got=%0b exp=1", init_busy); end
        req_valid = 1'b0;
    endtask

    task automatic test_init();
        int n, rs;
        logic ok, got;
        logic [1:0] d;
        Reset = 1'b0;
        count_init(n, rs);
        model_init();
        total++; if (n != 300) begin bad++; $display("FAIL init_cycles got=%0d exp=300", n); end
        total++; if (rs != 0)  begin bad++; $display("FAIL init_ready_seen got=%0d exp=0", rs); end
        game_req(1'b0, 3, 4, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd3)
            begin bad++; $display("FAIL init_read_3_4 ok=%0b valid=%0b data=%0d exp valid=1 data=3", ok, got, d); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL init_rsp_single got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_display();
        blank = 1'b1; DrawX = 10'd64; DrawY = 10'd32;
        tick();
        total++; if (tile_out !== 2'd3) begin bad++; $display("FAIL disp_64_32 got=%0d exp=3", tile_out); end
        DrawY = 10'd480;
        tick();
        total++; if (tile_out !== 2'd0) begin bad++; $display("FAIL disp_y480 got=%0d exp=0", tile_out); end
        DrawY = 10'd32; blank = 1'b0;
        tick();
        total++; if (tile_out !== 2'd0) begin bad++; $display("FAIL disp_blank0 got=%0d exp=0", tile_out); end
    endtask

    task automatic test_display_random();
        int x, y, e;
        logic bl;
        for (int i = 0; i < 80; i++) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            bl = ($urandom_range(0, 3) != 0);
            DrawX = 10'(x); DrawY = 10'(y); blank = bl;
            e = model_tile(x, y, bl);
            tick();
            total++; if (tile_out !== 2'(e))
                begin bad++; $display("FAIL disp_rand x=%0d y=%0d blank=%0b got=%0d exp=%0d", x, y, bl, tile_out, e); end
        end
        blank = 1'b0;
    endtask

    task automatic test_held_read();
        int pulses;
        logic [1:0] d;
        blank = 1'b1;
        req_we = 1'b0; req_row = 4'd2; req_col = 5'd5; req_wdata = '0; req_valid = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL held_ready_blank got=%0b exp=0", req_ready); end
        pulses = 0;
        repeat (4) begin
            tick();
            if (rsp_valid) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL held_early_rsp got=%0d exp=0", pulses); end
        blank = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL held_ready_release got=%0b exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        d = rsp_rdata;
        pulses = rsp_valid ? 1 : 0;
        total++; if (d !== 2'(model_read(2, 5)))
            begin bad++; $display("FAIL held_rdata got=%0d exp=%0d", d, model_read(2, 5)); end
        repeat (5) begin
            tick();
            if (rsp_valid) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_write_boundary();
        logic ok, got;
        logic [1:0] d;
        blank = 1'b0;
        game_req(1'b1, 14, 19, 2, ok, got, d);
        model_write(14, 19, 2);
        total++; if (!ok || got !== 1'b0) begin bad++; $display("FAIL wr_14_19 ok=%0b rsp=%0b exp ok=1 rsp=0", ok, got); end
        game_req(1'b0, 14, 19, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd2)
            begin bad++; $display("FAIL rd_14_19 valid=%0b data=%0d exp valid=1 data=2", got, d); end
        game_req(1'b1, 15, 0, 1, ok, got, d);
        total++; if (!ok) begin bad++; $display("FAIL wr_15_0 accepted=%0b exp=1", ok); end
        game_req(1'b0, 15, 0, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd0)
            begin bad++; $display("FAIL rd_15_0 valid=%0b data=%0d exp valid=1 data=0", got, d); end
        game_req(1'b0, 0, 0, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd0)
            begin bad++; $display("FAIL rd_0_0 valid=%0b data=%0d exp valid=1 data=0", got, d); end
    endtask

    task automatic test_back_to_back();
        int r, c, v, e, errs;
        logic we;
        errs = 0;
        blank = 1'b0;
        for (int i = 0; i < 200; i++) begin
            we = $urandom_range(0, 1);
            r  = $urandom_range(0, 15);
            c  = $urandom_range(0, 23);
            v  = $urandom_range(0, 3);
            req_we = we; req_row = 4'(r); req_col = 5'(c); req_wdata = 2'(v); req_valid = 1'b1;
            e = model_read(r, c);
            if (we) model_write(r, c, v);
            #1;
            if (req_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, req_ready);
            end
            tick();
            if (rsp_valid !== !we || (!we && rsp_rdata !== 2'(e))) begin
                errs++;
                $display("FAIL b2b_rsp i=%0d we=%0b r=%0d c=%0d valid=%0b data=%0d exp_data=%0d",
                         i, we, r, c, rsp_valid, rsp_rdata, e);
            end
        end
        req_valid = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_summary errors=%0d exp=0", errs); end
    endtask

`ifdef TILEMAP_WRITE_BUFFER_EN
    task automatic test_write_buffer();
        logic ok, got;
        logic [1:0] d;
        blank = 1'b1;
        req_we = 1'b1; req_row = 4'd2; req_col = 5'd2; req_wdata = 2'd0; req_valid = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wb_first_ready got=%0b exp=1", req_ready); end
        tick();
        model_write(2, 2, 0);
        req_row = 4'd3; req_col = 5'd3; req_wdata = 2'd1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wb_full_ready got=%0b exp=0", req_ready); end
        tick();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wb_full_hold got=%0b exp=0", req_ready); end
        blank = 1'b0;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wb_commit_ready got=%0b exp=0", req_ready); end
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wb_after_commit got=%0b exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        model_write(3, 3, 1);
        game_req(1'b0, 2, 2, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd0)
            begin bad++; $display("FAIL wb_rd_2_2 valid=%0b data=%0d exp=0", got, d); end
        game_req(1'b0, 3, 3, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd1)
            begin bad++; $display("FAIL wb_rd_3_3 valid=%0b data=%0d exp=1", got, d); end
    endtask
`endif

    task automatic test_reset_mid_init();
        int n, rs;
        logic ok, got;
        logic [1:0] d;
        blank = 1'b0;
        game_req(1'b0, 1, 2, 0, ok, got, d);
        req_we = 1'b0; req_row = 4'd1; req_col = 5'd2; req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        req_valid = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 2'd0)
            begin bad++; $display("FAIL rst_pending_rsp valid=%0b data=%0d exp 0/0", rsp_valid, rsp_rdata); end
        tick();
        Reset = 1'b0;
        repeat (100) tick();
        total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=1", init_busy); end
        Reset = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0 || tile_out !== 2'd0)
            begin bad++; $display("FAIL rst_mid_outputs ready=%0b tile=%0d exp 0/0", req_ready, tile_out); end
        tick();
        Reset = 1'b0;
        count_init(n, rs);
        model_init();
        total++; if (n != 300) begin bad++; $display("FAIL rst_reinit_cycles got=%0d exp=300", n); end
        game_req(1'b0, 0, 1, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'd1)
            begin bad++; $display("FAIL rst_rd_0_1 valid=%0b data=%0d exp=1", got, d); end
        game_req(1'b0, 14, 19, 0, ok, got, d);
        total++; if (!ok || got !== 1'b1 || d !== 2'(model_read(14, 19)))
            begin bad++; $display("FAIL rst_rd_14_19 valid=%0b data=%0d exp=%0d", got, d, model_read(14, 19)); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_display();
        test_display_random();
        test_held_read();
        test_write_boundary();
        test_back_to_back();
`ifdef TILEMAP_WRITE_BUFFER_EN
        test_write_buffer();
`endif
        test_display_random();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tilemap_ctrl.md
TILEMAP_CTRL -- requirements
Module: tilemap_ctrl

Interface
REQ-001 Parameters: ROWS, 15, tile rows; COLS, 20, tile columns; TILE_SHIFT, 5, log2 tile edge in pixels.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 blank  input  1  1 = active video, 0 = blanking interval.
REQ-005 DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-006 tile_out  output  2  tile code for the display path.
REQ-007 req_valid, req_we  input  1 each  game-port request valid; 1 = write, 0 = read.
REQ-008 req_row, req_col, req_wdata  input  4, 5, 2  tile address and write data.
REQ-009 req_ready  output  1  request accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-010 rsp_valid, rsp_rdata  output  1, 2  read response strobe and data.
REQ-011 init_busy  output  1  1 while the map initialisation sequence runs.

Function
REQ-012 Storage: ROWS*COLS entries of 2 bits, internal, single access per cycle, shared between the display path and the game port.
REQ-013 FSM states: INIT and RUN; INIT goes to RUN after the last entry is written; RUN persists until reset.
REQ-014 INIT: one entry per Clk, row-major from (0,0) to (14,19), value (row+col) mod 4; takes exactly 300 cycles; init_busy=1 and req_ready=0 throughout.
REQ-015 Display path in RUN with blank=1: read row=DrawY[8:5], col=DrawX[9:5]; tile_out is registered, latency 1 Clk.
REQ-016 Display out-of-range (row>=ROWS or col>=COLS), blank=0, or state INIT: tile_out=0 on the next cycle.
REQ-017 Arbitration: the display path owns storage whenever blank=1; the game port is granted only when blank=0.
REQ-018 req_ready = (state==RUN) and (blank==0), except as modified by REQ-025.
REQ-019 Read accepted at edge T: rsp_valid=1 for exactly one cycle after T, with rsp_rdata holding the entry value; otherwise rsp_valid=0.
REQ-020 Write accepted at edge T: entry updated at T; no response; a read accepted at T+1 returns the new value.
REQ-021 Out-of-range game address (row>=15 or col>=20): request still accepted; write ignored; read returns rsp_rdata=0.
REQ-022 Back-to-back accepts permitted every cycle while req_ready=1; a request held across blank=1 is neither dropped nor duplicated.

Reset
REQ-023 Reset asserted, including mid-INIT or mid-transaction: state=INIT, init counter=0, tile_out=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_busy=1, write buffer empty; INIT restarts from (0,0) after deassertion.
REQ-024 Any response pending at reset is discarded and never issued.

Configuration
REQ-025 TILEMAP_WRITE_BUFFER_EN defined: adds a 1-entry posted-write buffer.
- In RUN, writes are accepted during blank=1 when the buffer is empty (req_ready=1 for writes only); reads still wait for blank=0.
- The buffered write commits on the first blank=0 cycle, and req_ready=0 in that cycle.
- Buffer full: req_ready=0 while blank=1.
REQ-026 TILEMAP_WRITE_BUFFER_EN undefined: no buffer; REQ-018 applies unchanged.

Verification
REQ-027 Release reset with blank=0 -> init_busy=1 for exactly 300 cycles; then read (3,4) -> rsp_valid one cycle later, rsp_rdata=3.
REQ-028 RUN, blank=1, DrawX=64, DrawY=32 -> tile_out=3 next cycle; DrawY=480 -> tile_out=0; blank=0 -> tile_out=0.
REQ-029 Read request raised while blank=1 -> req_ready=0 and request held; blank falls -> accepted, rsp_rdata correct, exactly one rsp_valid pulse.
REQ-030 Write (14,19)=2, then read (14,19) -> 2; write (15,0)=1, then read (15,0) -> 0; read (0,0) -> 0 (unchanged).
REQ-031 Reset pulsed at INIT cycle 100 -> init_busy stays 1 for a further 300 cycles; entry (0,1) reads 1 afterwards.
REQ-032 With TILEMAP_WRITE_BUFFER_EN: write (2,2)=0 during blank=1 accepted -> second write stalls with req_ready=0; blank falls -> commit cycle with req_ready=0, then read (2,2) -> 0.
